// File: rtl/alu_pkg.sv
// Shared ALU definitions: the add/subtract opcode encoding and the status
// flag bundle. The adder/subtractor and the ALU result mux both use them.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit adder slice: one chunk of the split carry chain.
//   x, y : chunk operands
//   ci   : carry into the chunk
//   s    : chunk sum
//   co   : carry out of the chunk
module adder_chunk #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES chunks of WIDTH/STAGES bits; stage k adds chunk k using the carry
// registered by stage k-1. Fixed latency of STAGES cycles, 1 op/cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational)
//   a, b, c_in, sub     : operands, carry in, subtract (invert B) select
//   out_valid/out_ready : result handshake
//   sum, c_out, ovf,zero: registered result and status flags
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: STAGES must be >= 1 and divide WIDTH");
  end

  // Stage registers: operands ride along until their chunk is consumed,
  // the partial sum accumulates low chunks, c_q carries between chunks.
  logic [STAGES-1:0]            vld_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  alu_flags_t                   flags_q, flags_d;

  // Per-stage inputs (stage 0 straight from the ports) and chunk results.
  logic [STAGES-1:0]            x_c, ch_co;
  logic [STAGES-1:0][WIDTH-1:0] x_a, x_b, x_s, s_d;
  logic [STAGES-1:0][CHUNK-1:0] ch_s;

  logic advance;

  // Global enable: the whole pipe moves or the whole pipe holds.
  assign advance  = ~vld_q[LAST] | out_ready;
  assign in_ready = advance;

  always_comb begin
    x_a[0] = a;
    x_b[0] = (sub == OP_SUB) ? ~b : b;
    x_s[0] = '0;
    x_c[0] = c_in;
    for (int k = 1; k < STAGES; k++) begin
      x_a[k] = a_q[k-1];
      x_b[k] = b_q[k-1];
      x_s[k] = s_q[k-1];
      x_c[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    adder_chunk #(.W(CHUNK)) u_chunk (
      .x  (x_a[k][k*CHUNK +: CHUNK]),
      .y  (x_b[k][k*CHUNK +: CHUNK]),
      .ci (x_c[k]),
      .s  (ch_s[k]),
      .co (ch_co[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = x_s[k];
      s_d[k][k*CHUNK +: CHUNK] = ch_s[k];
    end
  end

  // Flags are formed in the last stage so every output comes from a flop.
  // The MSBs of the operands are still intact there (top chunk unconsumed).
  always_comb begin
    flags_d       = '0;
    flags_d.c_out = ch_co[LAST];
    flags_d.zero  = ~|s_d[LAST];
    flags_d.ovf   = (x_a[LAST][WIDTH-1] == x_b[LAST][WIDTH-1]) &&
                    (s_d[LAST][WIDTH-1] != x_a[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      flags_q <= '0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
      a_q     <= x_a;
      b_q     <= x_b;
      s_q     <= s_d;
      c_q     <= ch_co;
      flags_q <= flags_d;
    end
  end

  // Consumed operand chunks and last-stage operand copies are never read.
  logic unused_bits;
  assign unused_bits = ^{x_a, x_b, x_s, c_q[LAST]};

  assign out_valid = vld_q[LAST];
  assign sum       = s_q[LAST];
  assign c_out     = flags_q.c_out;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
module tb_pipelined_add_sub;
  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, c_in, sub, out_valid, out_ready;
  logic c_out, ovf, zero;
  logic [WIDTH-1:0] a, b, sum;

  pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] sum;
    logic c, v, z;
    int   t;
    bit   lat;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int or_mode = 0;  // 0: out_ready=1, 1: random, 2: driven by main

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Directed vectors with hand-computed results.
  logic [63:0] ta [10] = '{64'd10, 64'd100, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                           64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                           64'h0000_0001_0000_0000, 64'd5, 64'h1234};
  logic [63:0] tb_ [10] = '{64'd20, 64'd1, 64'd0, 64'd1, 64'd2,
                            64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                            64'h0000_0000_FFFF_FFFF, 64'd5, 64'h1234};
  bit tci [10] = '{0, 1, 1, 0, 1, 0, 0, 0, 1, 0};
  bit tsb [10] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1};
  logic [63:0] ts [10] = '{64'd30, 64'd99, 64'd0, 64'h8000_0000_0000_0000, 64'd4,
                           64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'h0000_0001_FFFF_FFFF,
                           64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
  bit tc [10] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0};
  bit tv [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
  bit tz [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 1, 0};

  // out_ready driver
  initial forever begin
    @(negedge clk);
    if (or_mode == 0) out_ready = 1'b1;
    else if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard
  logic        pend = 1'b0;
  logic [63:0] held_sum;
  logic [2:0]  held_flg;
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) pend = 1'b0;
    else begin
      if (pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_sum", sum, held_sum);
        chk("hold_flags", 64'({c_out, ovf, zero}), 64'(held_flg));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=sum %h required=no output", sum);
        end else begin
          e = q.pop_front();
          chk("sum", sum, e.sum);
          chk("flags", 64'({c_out, ovf, zero}), 64'({e.c, e.v, e.z}));
          if (e.lat) chk("latency", 64'(cyc - e.t), 64'(STAGES));
        end
      end
      pend     = out_valid && !out_ready;
      held_sum = sum;
      held_flg = {c_out, ovf, zero};
    end
  end

  // Presents a beat starting at the current negedge; returns at the negedge
  // after the accepting edge with in_valid still high.
  task automatic send(input logic [63:0] av, bv, input logic ci, sb,
                      input logic [63:0] es, input logic ec, ev, ez,
                      input bit lat, input bit track);
    bit acc;
    int n = 0;
    a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
    forever begin
      #1;
      acc = in_ready;
      if (acc && track) q.push_back('{es, ec, ev, ez, cyc, lat});
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=not accepted required=accepted");
        break;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    repeat (STAGES + 2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 64'd9; b = 64'd9; c_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    // 1: reset held 3 cycles with in_valid asserted
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", sum, 64'd0);
      chk("rst_flags", 64'({c_out, ovf, zero}), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(negedge clk);

    // 2-4: latency, carry across chunks, subtract/overflow
    send(64'd5, 64'd7, 0, 0, 64'd12, 0, 0, 0, 1, 1);
    in_valid = 1'b0;
    drain();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'd0, 1, 0, 1, 1, 1);
    send(64'd3, 64'd5, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1, 1);
    send(64'h8000_0000_0000_0000, 64'd1, 1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 1, 1);
    in_valid = 1'b0;
    drain();

    // back-to-back stream, no backpressure: 1 op/cycle at fixed latency
    for (int i = 0; i < 10; i++)
      send(ta[i], tb_[i], tci[i], tsb[i], ts[i], tc[i], tv[i], tz[i], 1, 1);
    in_valid = 1'b0;
    drain();

    // 5: same stream under random backpressure
    or_mode = 1;
    for (int i = 0; i < 10; i++)
      send(ta[i], tb_[i], tci[i], tsb[i], ts[i], tc[i], tv[i], tz[i], 0, 1);
    in_valid = 1'b0;
    drain();

    // full pipeline with out_ready low: new beat must be refused
    or_mode = 2;
    out_ready = 1'b0;
    send(64'd40, 64'd2, 0, 0, 64'd42, 0, 0, 0, 0, 1);
    in_valid = 1'b0;
    repeat (STAGES + 1) @(negedge clk);
    a = 64'd1; b = 64'd1; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      #1 chk("in_ready_full", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(64'd1, 64'd1, 0, 0, 64'd2, 0, 0, 0, 0, 1);
    in_valid = 1'b0;
    or_mode = 0;
    drain();

    // 6: reset mid-stream after 2 accepts; reset beats an accept
    send(64'd11, 64'd11, 0, 0, 64'd0, 0, 0, 0, 0, 0);
    send(64'd12, 64'd12, 0, 0, 64'd0, 0, 0, 0, 0, 0);
    rst = 1'b1; a = 64'd13; b = 64'd13;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    send(64'd21, 64'd1, 1, 1, 64'd20, 1, 0, 0, 1, 1);
    in_valid = 1'b0;
    drain();
    chk("final_queue", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
